// File: rtl/poly_add_stream.sv
// Streams two N-coefficient polynomials from synchronous RAMs and writes their
// coefficient-wise sum mod NEWHOPE_Q to a destination RAM, in address order.
module poly_add_stream #(
  parameter int N         = 1024,
  parameter int ADDR_W    = 10,
  parameter int NEWHOPE_Q = 12289
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       dia,
  input  logic [15:0]       dib,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [14:0]       Q1        = 15'(NEWHOPE_Q);
  localparam logic [14:0]       Q2        = 15'(2 * NEWHOPE_Q);

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_a1;
  logic [ADDR_W-1:0] r_a2;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_v1;
  logic              r_v2;
  logic              r_wr_en;
  logic [14:0]       r_sum;
  logic [15:0]       r_dout;

  logic              w_rd_en;
  logic              w_last_rd;
  logic              w_last_wr;
  logic [13:0]       w_red;
  logic              w_unused_hi;

  assign w_last_rd   = (r_rd_addr == LAST_ADDR);
  assign w_last_wr   = r_wr_en && (r_wr_addr == LAST_ADDR);
  // Upper RAM bits carry no coefficient information.
  assign w_unused_hi = ^{dia[15:14], dib[15:14]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start)     w_next = S_READ;
      S_READ:  if (w_last_rd) w_next = S_DRAIN;
      S_DRAIN: if (w_last_wr) w_next = S_DONE;
      S_DONE:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      S_READ: begin
        w_rd_en = 1'b1;
        busy    = 1'b1;
      end
      S_DRAIN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Read address is rewound on accept so cycle 1 already presents address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_rd_addr <= '0;
    end else if (w_rd_en && !w_last_rd) begin
      r_rd_addr <= r_rd_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_a1 <= '0;
    end else begin
      r_v1 <= w_rd_en;
      if (w_rd_en) r_a1 <= r_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2  <= 1'b0;
      r_a2  <= '0;
      r_sum <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a2  <= r_a1;
        r_sum <= {1'b0, dia[13:0]} + {1'b0, dib[13:0]};
      end
    end
  end

  // Sum of two 14-bit values is below 3Q, so two conditional subtractions suffice.
  always_comb begin
    if (r_sum >= Q2) begin
      w_red = 14'(r_sum - Q2);
    end else if (r_sum >= Q1) begin
      w_red = 14'(r_sum - Q1);
    end else begin
      w_red = r_sum[13:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_dout    <= '0;
    end else begin
      r_wr_en <= r_v2;
      if (r_v2) begin
        r_wr_addr <= r_a2;
        r_dout    <= {2'b00, w_red};
      end
    end
  end

  assign rd_en   = w_rd_en;
  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign dout    = r_dout;

endmodule
